// File: rtl/sdx_kernel_wizard_0_example_vadd_scheduler.sv
// Job-level scheduler for the vadd kernel: splits one host job into chunks,
// starts read/write masters per chunk and waits for both completions.
module sdx_kernel_wizard_0_example_vadd_scheduler #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
   parameter int unsigned C_CHUNK_BYTES      = 65536
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          ap_start,
   output logic                          ap_done,
   output logic                          ap_ready,
   output logic                          ap_idle,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_rd_addr_offset,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_wr_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
   output logic                          rd_start,
   output logic                          wr_start,
   input  logic                          rd_done,
   input  logic                          wr_done,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_offset,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_offset,
   output logic [C_XFER_SIZE_WIDTH-1:0]  chunk_xfer_size_in_bytes,
   output logic [C_XFER_SIZE_WIDTH-1:0]  stat_cycle_count,
   output logic                          err_spurious_done
);

   localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned XW = C_XFER_SIZE_WIDTH;
   localparam logic [XW-1:0] CHUNK = XW'(C_CHUNK_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] remaining_q, remaining_d;
   logic [XW-1:0] chunk_q, chunk_d;
   logic [XW-1:0] cyc_q, cyc_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic          start_q, start_d;
   logic          done_q, done_d;
   logic          idle_q, idle_d;
   logic          err_q, err_d;
   logic          rd_seen_q, rd_seen_d;
   logic          wr_seen_q, wr_seen_d;
   logic          rd_sat, wr_sat;
   logic [XW-1:0] rem_next;

   function automatic logic [XW-1:0] chunk_of(input logic [XW-1:0] rem);
      return (rem > CHUNK) ? CHUNK : rem;
   endfunction

   function automatic logic [XW-1:0] sat_inc(input logic [XW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      chunk_d     = chunk_q;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      start_d     = 1'b0;
      done_d      = 1'b0;
      idle_d      = 1'b0;
      rd_seen_d   = rd_seen_q;
      wr_seen_d   = wr_seen_q;
      rd_sat      = rd_seen_q | rd_done;
      wr_sat      = wr_seen_q | wr_done;
      rem_next    = remaining_q - chunk_q;
      cyc_d       = (state_q == S_IDLE) ? cyc_q : sat_inc(cyc_q);
      // Any completion pulse outside WAIT has no chunk to belong to.
      err_d       = err_q | ((rd_done | wr_done) & (state_q != S_WAIT));

      case (state_q)
         S_IDLE: begin
            idle_d = 1'b1;
            if (ap_start) begin
               idle_d      = 1'b0;
               rd_addr_d   = ctrl_rd_addr_offset;
               wr_addr_d   = ctrl_wr_addr_offset;
               remaining_d = ctrl_xfer_size_in_bytes;
               cyc_d       = '0;
               err_d       = 1'b0;
               if (ctrl_xfer_size_in_bytes == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  start_d = 1'b1;
                  chunk_d = chunk_of(ctrl_xfer_size_in_bytes);
               end
            end
         end
         S_ISSUE: begin
            rd_seen_d = 1'b0;
            wr_seen_d = 1'b0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            rd_seen_d = rd_sat;
            wr_seen_d = wr_sat;
            if (rd_sat && wr_sat) begin
               remaining_d = rem_next;
               rd_addr_d   = rd_addr_q + AW'(chunk_q);
               wr_addr_d   = wr_addr_q + AW'(chunk_q);
               if (rem_next != '0) begin
                  state_d = S_ISSUE;
                  start_d = 1'b1;
                  chunk_d = chunk_of(rem_next);
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            idle_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            idle_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         chunk_q     <= '0;
         cyc_q       <= '0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         idle_q      <= 1'b1;
         err_q       <= 1'b0;
         rd_seen_q   <= 1'b0;
         wr_seen_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         chunk_q     <= chunk_d;
         cyc_q       <= cyc_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         start_q     <= start_d;
         done_q      <= done_d;
         idle_q      <= idle_d;
         err_q       <= err_d;
         rd_seen_q   <= rd_seen_d;
         wr_seen_q   <= wr_seen_d;
      end
   end

   assign ap_done                  = done_q;
   assign ap_ready                 = done_q;
   assign ap_idle                  = idle_q;
   assign rd_start                 = start_q;
   assign wr_start                 = start_q;
   assign rd_addr_offset           = rd_addr_q;
   assign wr_addr_offset           = wr_addr_q;
   assign chunk_xfer_size_in_bytes = chunk_q;
   assign stat_cycle_count         = cyc_q;
   assign err_spurious_done        = err_q;

endmodule

// File: tb/tb_sdx_kernel_wizard_0_example_vadd_scheduler.sv
// Scoreboard bench for the vadd scheduler: a job-level model queues expected
// start pulses and completions; a monitor pops and compares them.
module tb_sdx_kernel_wizard_0_example_vadd_scheduler;

   localparam int AW = 64;
   localparam int XW = 32;
   localparam int CH = 65536;

   logic          aclk = 1'b0;
   logic          areset;
   logic          ap_start;
   logic          ap_done, ap_ready, ap_idle;
   logic [AW-1:0] ctrl_rd_addr_offset, ctrl_wr_addr_offset;
   logic [XW-1:0] ctrl_xfer_size_in_bytes;
   logic          rd_start, wr_start;
   logic          rd_done, wr_done;
   logic [AW-1:0] rd_addr_offset, wr_addr_offset;
   logic [XW-1:0] chunk_xfer_size_in_bytes;
   logic [XW-1:0] stat_cycle_count;
   logic          err_spurious_done;

   sdx_kernel_wizard_0_example_vadd_scheduler #(
      .C_M_AXI_ADDR_WIDTH(AW),
      .C_XFER_SIZE_WIDTH (XW),
      .C_CHUNK_BYTES     (CH)
   ) dut (
      .aclk                    (aclk),
      .areset                  (areset),
      .ap_start                (ap_start),
      .ap_done                 (ap_done),
      .ap_ready                (ap_ready),
      .ap_idle                 (ap_idle),
      .ctrl_rd_addr_offset     (ctrl_rd_addr_offset),
      .ctrl_wr_addr_offset     (ctrl_wr_addr_offset),
      .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
      .rd_start                (rd_start),
      .wr_start                (wr_start),
      .rd_done                 (rd_done),
      .wr_done                 (wr_done),
      .rd_addr_offset          (rd_addr_offset),
      .wr_addr_offset          (wr_addr_offset),
      .chunk_xfer_size_in_bytes(chunk_xfer_size_in_bytes),
      .stat_cycle_count        (stat_cycle_count),
      .err_spurious_done       (err_spurious_done)
   );

   always #5 aclk = ~aclk;

   int unsigned cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      int unsigned   cy;
      logic [31:0]   chunk;
      logic [63:0]   rd;
      logic [63:0]   wr;
   } start_exp_t;

   typedef struct {
      int unsigned   cy;
      logic [31:0]   cnt;
   } done_exp_t;

   start_exp_t exp_start[$];
   done_exp_t  exp_done[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a start or a done.
   initial begin
      start_exp_t se;
      done_exp_t  de;
      forever begin
         @(negedge aclk);
         if (rd_start === 1'b1 || wr_start === 1'b1) begin
            chk("wr_start_eq_rd_start", 64'(wr_start), 64'(rd_start));
            if (exp_start.size() == 0) begin
               fail_now("unexpected_start");
            end else begin
               se = exp_start.pop_front();
               chk("start_cycle", 64'(cyc), 64'(se.cy));
               chk("chunk_size", 64'(chunk_xfer_size_in_bytes), 64'(se.chunk));
               chk("rd_addr", rd_addr_offset, se.rd);
               chk("wr_addr", wr_addr_offset, se.wr);
               chk("idle_during_start", 64'(ap_idle), 64'd0);
            end
         end
         if (ap_done === 1'b1 || ap_ready === 1'b1) begin
            chk("ap_ready_eq_ap_done", 64'(ap_ready), 64'(ap_done));
            if (exp_done.size() == 0) begin
               fail_now("unexpected_ap_done");
            end else begin
               de = exp_done.pop_front();
               chk("done_cycle", 64'(cyc), 64'(de.cy));
               chk("cycle_count", 64'(stat_cycle_count), 64'(de.cnt));
            end
         end
      end
   end

   function automatic logic [31:0] min_chunk(input logic [31:0] rem);
      return (rem < 32'(CH)) ? rem : 32'(CH);
   endfunction

   // Runs one job and acts as both masters. kr_fix/kw_fix > 0 fix the done
   // delays (cycles after start); abort_at >= 0 asserts reset in that chunk's WAIT.
   task automatic run_job(input logic [63:0] rb, input logic [63:0] wb, input logic [31:0] sz,
                          input int kr_fix, input int kw_fix, input int abort_at);
      int unsigned a, d;
      logic [31:0] rem, c;
      logic [63:0] off;
      int kr, kw, k, t, idx;
      t = 0;
      while (ap_idle !== 1'b1 && t < 100) begin
         @(negedge aclk);
         t++;
      end
      if (ap_idle !== 1'b1) begin
         fail_now("wait_idle_timeout");
         return;
      end
      ctrl_rd_addr_offset     = rb;
      ctrl_wr_addr_offset     = wb;
      ctrl_xfer_size_in_bytes = sz;
      ap_start = 1'b1;
      a   = cyc;
      rem = sz;
      off = '0;
      if (sz == 0) exp_done.push_back('{a + 1, 32'd0});
      else         exp_start.push_back('{a + 1, min_chunk(sz), rb, wb});
      @(negedge aclk);
      ap_start = 1'b0;
      idx = 0;
      while (rem != 0) begin
         t = 0;
         while (rd_start !== 1'b1 && t < 100) begin
            @(negedge aclk);
            t++;
         end
         if (rd_start !== 1'b1) begin
            fail_now("wait_start_timeout");
            return;
         end
         if (idx == 0) chk("err_cleared_on_accept", 64'(err_spurious_done), 64'd0);
         c = min_chunk(rem);
         if (idx == abort_at) begin
            @(negedge aclk);
            @(negedge aclk);
            areset = 1'b1;
            @(negedge aclk);
            chk("rst_ap_idle", 64'(ap_idle), 64'd1);
            chk("rst_ap_done", 64'(ap_done), 64'd0);
            chk("rst_rd_start", 64'(rd_start), 64'd0);
            chk("rst_rd_addr", rd_addr_offset, 64'd0);
            chk("rst_wr_addr", wr_addr_offset, 64'd0);
            chk("rst_chunk", 64'(chunk_xfer_size_in_bytes), 64'd0);
            chk("rst_count", 64'(stat_cycle_count), 64'd0);
            areset = 1'b0;
            return;
         end
         kr = (kr_fix > 0) ? kr_fix : int'($urandom_range(1, 12));
         kw = (kw_fix > 0) ? kw_fix : int'($urandom_range(1, 12));
         k  = (kr > kw) ? kr : kw;
         for (int j = 1; j <= k; j++) begin
            @(negedge aclk);
            rd_done = (j == kr);
            wr_done = (j == kw);
         end
         d   = cyc;
         rem = rem - c;
         off = off + 64'(c);
         if (rem != 0) exp_start.push_back('{d + 1, min_chunk(rem), rb + off, wb + off});
         else          exp_done.push_back('{d + 1, d - a});
         @(negedge aclk);
         rd_done = 1'b0;
         wr_done = 1'b0;
         idx++;
      end
   endtask

   initial begin
      areset = 1'b1;
      ap_start = 1'b0;
      rd_done = 1'b0;
      wr_done = 1'b0;
      ctrl_rd_addr_offset = '0;
      ctrl_wr_addr_offset = '0;
      ctrl_xfer_size_in_bytes = '0;
      repeat (3) @(negedge aclk);
      chk("reset_ap_idle", 64'(ap_idle), 64'd1);
      chk("reset_ap_done", 64'(ap_done), 64'd0);
      chk("reset_ap_ready", 64'(ap_ready), 64'd0);
      chk("reset_start", 64'({rd_start, wr_start}), 64'd0);
      chk("reset_rd_addr", rd_addr_offset, 64'd0);
      chk("reset_wr_addr", wr_addr_offset, 64'd0);
      chk("reset_chunk", 64'(chunk_xfer_size_in_bytes), 64'd0);
      chk("reset_count", 64'(stat_cycle_count), 64'd0);
      chk("reset_err", 64'(err_spurious_done), 64'd0);
      areset = 1'b0;
      @(negedge aclk);

      // Single chunk, both dones together 20 cycles after start.
      run_job(64'h1000, 64'h9000, 32'd4096, 20, 20, -1);
      // Multi-chunk: 65536 x3 + 3392.
      run_job(64'h0, 64'h4_0000, 32'd200000, 0, 0, -1);
      // Write done well before read done.
      run_job(64'h2000, 64'h8000, 32'd8192, 13, 3, -1);
      // Zero-size job.
      run_job(64'h1234_0000, 64'h5678_0000, 32'd0, 0, 0, -1);

      // Spurious done while idle.
      repeat (3) @(negedge aclk);
      rd_done = 1'b1;
      @(negedge aclk);
      rd_done = 1'b0;
      chk("spurious_err_set", 64'(err_spurious_done), 64'd1);
      chk("spurious_stays_idle", 64'(ap_idle), 64'd1);
      // Address wrap on the second chunk; accept also clears the error flag.
      run_job(64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_FFFF_8000, 32'd131072, 0, 0, -1);

      for (int r = 0; r < 6; r++) begin
         run_job({$urandom, $urandom}, {$urandom, $urandom},
                 32'($urandom_range(0, 4800)) * 32'd64, 0, 0, -1);
      end

      // Reset in WAIT of the second chunk, then a fresh job.
      run_job(64'h10_0000, 64'h20_0000, 32'd200000, 0, 0, 1);
      run_job(64'h3000, 64'hA000, 32'd65600, 0, 0, -1);

      repeat (6) @(negedge aclk);
      chk("start_queue_drained", 64'(exp_start.size()), 64'd0);
      chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
      chk("final_idle", 64'(ap_idle), 64'd1);
      chk("final_err_clear", 64'(err_spurious_done), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
